axi_read_route_ctrl: RTL and testbench

- Read-path routing controller for a 1-master, 4-slave AXI interconnect.
- Decodes ARADDR to a slave index and steers the AR handshake to that slave.
- Records each accepted read in an in-order outstanding-transaction FIFO.
- Drives the 2-bit select of the R-channel mux and the RREADY 1-to-4 demux from the FIFO head, holding it until RLAST completes that burst.

---
 rtl/axi_ic_defs.sv | 19 +
 rtl/route_id_fifo.sv | 49 ++++
 rtl/axi_read_route_ctrl.sv | 86 ++++++++
 tb/tb_axi_read_route_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ic_defs.sv
// rtl/axi_ic_defs.sv - shared interconnect constants for the read-route controller
package axi_ic_defs;

  localparam int NUM_SLAVES = 4;
  localparam int SEL_WIDTH  = 2;

  typedef logic [SEL_WIDTH-1:0] sel_t;

  localparam sel_t SLV0 = 2'd0;
  localparam sel_t SLV1 = 2'd1;
  localparam sel_t SLV2 = 2'd2;
  localparam sel_t SLV3 = 2'd3;

  // The slave index occupies the top SEL_WIDTH bits of the address.
  function automatic int dec_lsb(input int addr_width);
    return addr_width - SEL_WIDTH;
  endfunction

endpackage

// File: rtl/route_id_fifo.sv
// rtl/route_id_fifo.sv - in-order FIFO of slave indices for accepted, uncompleted reads
module route_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/axi_read_route_ctrl.sv
// rtl/axi_read_route_ctrl.sv - AR decode/steer and in-order R-channel select for 1x4 read path
module axi_read_route_ctrl
  import axi_ic_defs::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               ACLK,
  input  logic                               ARESET,
  input  logic [ADDR_WIDTH-1:0]              S00_AXI_araddr,
  input  logic                               S00_AXI_arvalid,
  output logic                               S00_AXI_arready,
  output logic [NUM_SLAVES-1:0]              M_arvalid,
  input  logic [NUM_SLAVES-1:0]              M_arready,
  output logic [SEL_WIDTH-1:0]               ar_sel,
  input  logic [NUM_SLAVES-1:0]              M_rvalid,
  input  logic [NUM_SLAVES-1:0]              M_rlast,
  input  logic                               S00_AXI_rready,
  output logic                               S00_AXI_rvalid,
  output logic [SEL_WIDTH-1:0]               r_sel,
  output logic                               r_active,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding
);

  localparam int DEC_LSB = dec_lsb(ADDR_WIDTH);
  localparam int CW      = $clog2(MAX_OUTSTANDING) + 1;

  sel_t           dec;
  sel_t           last_sel;
  sel_t           head;
  logic           full;
  logic           empty;
  logic [CW-1:0]  count;
  logic           ordering_ok;
  logic           can_issue;
  logic           push;
  logic           pop;
  logic           unused_addr_bits;

  assign dec              = S00_AXI_araddr[DEC_LSB +: SEL_WIDTH];
  assign unused_addr_bits = ^S00_AXI_araddr[DEC_LSB-1:0];
  assign ar_sel           = dec;

  // A read to a new slave waits for all earlier reads to drain so R stays in order.
  always_comb begin
    ordering_ok     = empty || (dec == last_sel);
    can_issue       = !ARESET && !full && ordering_ok;
    M_arvalid       = '0;
    if (S00_AXI_arvalid && can_issue) begin
      M_arvalid = NUM_SLAVES'(1) << dec;
    end
    S00_AXI_arready = M_arready[dec] && can_issue;
    push            = S00_AXI_arvalid && S00_AXI_arready;

    r_active        = !ARESET && !empty;
    r_sel           = r_active ? head : SLV0;
    S00_AXI_rvalid  = r_active && M_rvalid[r_sel];
    pop             = S00_AXI_rvalid && S00_AXI_rready && M_rlast[r_sel];
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      last_sel <= SLV0;
    end else if (push) begin
      last_sel <= dec;
    end
  end

  route_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (SEL_WIDTH)
  ) u_fifo (
    .clk       (ACLK),
    .rst       (ARESET),
    .push      (push),
    .push_data (dec),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign outstanding = count;

endmodule

// File: tb/tb_axi_read_route_ctrl.sv
// tb/tb_axi_read_route_ctrl.sv - self-checking bench for axi_read_route_ctrl
module tb_axi_read_route_ctrl;

  localparam int MAXO = 4;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] S00_AXI_araddr;
  logic        S00_AXI_arvalid;
  logic        S00_AXI_arready;
  logic [3:0]  M_arvalid;
  logic [3:0]  M_arready;
  logic [1:0]  ar_sel;
  logic [3:0]  M_rvalid;
  logic [3:0]  M_rlast;
  logic        S00_AXI_rready;
  logic        S00_AXI_rvalid;
  logic [1:0]  r_sel;
  logic        r_active;
  logic [2:0]  outstanding;

  axi_read_route_ctrl #(.ADDR_WIDTH(32), .MAX_OUTSTANDING(MAXO)) dut (
    .ACLK            (ACLK),
    .ARESET          (ARESET),
    .S00_AXI_araddr  (S00_AXI_araddr),
    .S00_AXI_arvalid (S00_AXI_arvalid),
    .S00_AXI_arready (S00_AXI_arready),
    .M_arvalid       (M_arvalid),
    .M_arready       (M_arready),
    .ar_sel          (ar_sel),
    .M_rvalid        (M_rvalid),
    .M_rlast         (M_rlast),
    .S00_AXI_rready  (S00_AXI_rready),
    .S00_AXI_rvalid  (S00_AXI_rvalid),
    .r_sel           (r_sel),
    .r_active        (r_active),
    .outstanding     (outstanding)
  );

  always #5 ACLK = ~ACLK;

  int total  = 0;
  int passes = 0;

  // Reference model: queue of slave indices still owed an RLAST, oldest first.
  int q[$];
  int m_last = 0;
  bit s_rst, s_push, s_pop;
  int s_dec;

  typedef struct {
    bit       rst;
    bit [1:0] sel;
    bit       arv;
    bit [3:0] marr;
    bit [3:0] mrv;
    bit [3:0] mrl;
    bit       rrdy;
    bit       e_arr;
    bit [3:0] e_marv;
    bit       e_rv;
    bit [1:0] e_rsel;
    bit       e_act;
    int       e_out;
  } vec_t;

  vec_t vec [10];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
  endtask

  task automatic set_in(input bit rst, input int sel, input bit arv,
                        input bit [3:0] marr, input bit [3:0] mrv,
                        input bit [3:0] mrl, input bit rrdy);
    logic [1:0] s2;
    s2 = sel[1:0];
    ARESET          = rst;
    S00_AXI_araddr  = {s2, 30'($urandom)};
    S00_AXI_arvalid = arv;
    M_arready       = marr;
    M_rvalid        = mrv;
    M_rlast         = mrl;
    S00_AXI_rready  = rrdy;
  endtask

  // Let inputs settle, then compare every output against the model's rules.
  task automatic settle();
    int  n, dec, hsel;
    bit  can, e_arr, e_rv, e_act;
    int  e_marv, e_rsel;
    #1;
    n      = q.size();
    dec    = int'(S00_AXI_araddr[31:30]);
    can    = !ARESET && (n < MAXO) && (n == 0 || dec == m_last);
    e_arr  = can && M_arready[dec];
    e_marv = (can && S00_AXI_arvalid) ? (1 << dec) : 0;
    hsel   = (n == 0) ? 0 : q[0];
    e_act  = !ARESET && (n != 0);
    e_rsel = e_act ? hsel : 0;
    e_rv   = e_act && M_rvalid[hsel];
    chk("m_ar_sel", int'(ar_sel), dec);
    chk("m_arready", int'(S00_AXI_arready), int'(e_arr));
    chk("m_arvalid", int'(M_arvalid), e_marv);
    chk("m_r_active", int'(r_active), int'(e_act));
    chk("m_r_sel", int'(r_sel), e_rsel);
    chk("m_rvalid", int'(S00_AXI_rvalid), int'(e_rv));
    chk("m_outstanding", int'(outstanding), n);
    s_rst  = ARESET;
    s_dec  = dec;
    s_push = S00_AXI_arvalid && e_arr;
    s_pop  = e_rv && S00_AXI_rready && M_rlast[hsel];
  endtask

  task automatic tick();
    @(posedge ACLK);
    if (s_rst) begin
      q.delete();
      m_last = 0;
    end else begin
      if (s_pop) void'(q.pop_front());
      if (s_push) begin
        q.push_back(s_dec);
        m_last = s_dec;
      end
    end
    @(negedge ACLK);
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic do_reset();
    set_in(1, 0, 0, 4'h0, 4'h0, 4'h0, 0);
    cyc();
    cyc();
  endtask

  task automatic drain();
    int h;
    for (int k = 0; k < 32 && q.size() > 0; k++) begin
      h = q[0];
      set_in(0, 0, 0, 4'h0, 4'(1 << h), 4'(1 << h), 1);
      cyc();
    end
    set_in(0, 0, 0, 4'h0, 4'h0, 4'h0, 0);
    settle();
    chk("drain_outstanding", int'(outstanding), 0);
    tick();
  endtask

  initial begin
    vec[0] = '{1, 2'd2, 1, 4'hf, 4'hf, 4'h0, 0, 0, 4'b0000, 0, 2'd0, 0, 0};
    vec[1] = '{0, 2'd2, 1, 4'b0100, 4'h0, 4'h0, 0, 1, 4'b0100, 0, 2'd0, 0, 0};
    vec[2] = '{0, 2'd1, 1, 4'hf, 4'h0, 4'h0, 0, 0, 4'b0000, 0, 2'd2, 1, 1};
    vec[3] = '{0, 2'd2, 1, 4'h0, 4'b0100, 4'h0, 1, 0, 4'b0100, 1, 2'd2, 1, 1};
    vec[4] = '{0, 2'd0, 0, 4'h0, 4'b0101, 4'b0100, 1, 0, 4'b0000, 1, 2'd2, 1, 1};
    vec[5] = '{0, 2'd1, 1, 4'hf, 4'b0010, 4'h0, 0, 1, 4'b0010, 0, 2'd0, 0, 0};
    vec[6] = '{0, 2'd1, 0, 4'h0, 4'b0001, 4'b0001, 1, 0, 4'b0000, 0, 2'd1, 1, 1};
    vec[7] = '{0, 2'd1, 0, 4'h0, 4'b0010, 4'b0010, 0, 0, 4'b0000, 1, 2'd1, 1, 1};
    vec[8] = '{0, 2'd1, 0, 4'h0, 4'b0010, 4'b0010, 1, 0, 4'b0000, 1, 2'd1, 1, 1};
    vec[9] = '{0, 2'd0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 4'b0000, 0, 2'd0, 0, 0};

    set_in(1, 0, 0, 4'h0, 4'h0, 4'h0, 0);
    @(negedge ACLK);
    do_reset();

    // Table-driven vectors, starting from an empty controller.
    for (int i = 0; i < 10; i++) begin
      set_in(vec[i].rst, int'(vec[i].sel), vec[i].arv, vec[i].marr,
             vec[i].mrv, vec[i].mrl, vec[i].rrdy);
      settle();
      chk($sformatf("vec%0d_arready", i), int'(S00_AXI_arready), int'(vec[i].e_arr));
      chk($sformatf("vec%0d_arvalid", i), int'(M_arvalid), int'(vec[i].e_marv));
      chk($sformatf("vec%0d_rvalid", i), int'(S00_AXI_rvalid), int'(vec[i].e_rv));
      chk($sformatf("vec%0d_r_sel", i), int'(r_sel), int'(vec[i].e_rsel));
      chk($sformatf("vec%0d_r_active", i), int'(r_active), int'(vec[i].e_act));
      chk($sformatf("vec%0d_outst", i), int'(outstanding), vec[i].e_out);
      tick();
    end

    // Reset in the middle of a burst to slave 1.
    set_in(0, 1, 1, 4'hf, 4'h0, 4'h0, 0);
    cyc();
    cyc();
    set_in(0, 1, 0, 4'h0, 4'b0010, 4'h0, 1);
    settle();
    chk("rstmid_beat_rvalid", int'(S00_AXI_rvalid), 1);
    chk("rstmid_outst", int'(outstanding), 2);
    tick();
    set_in(1, 1, 1, 4'hf, 4'b0010, 4'h0, 1);
    settle();
    chk("rstmid_in_arready", int'(S00_AXI_arready), 0);
    chk("rstmid_in_arvalid", int'(M_arvalid), 0);
    chk("rstmid_in_rvalid", int'(S00_AXI_rvalid), 0);
    tick();
    set_in(0, 1, 0, 4'h0, 4'h0, 4'h0, 0);
    settle();
    chk("rstmid_outst0", int'(outstanding), 0);
    chk("rstmid_active0", int'(r_active), 0);
    chk("rstmid_arready0", int'(S00_AXI_arready), 0);
    chk("rstmid_arvalid0", int'(M_arvalid), 0);
    tick();

    // Single 4-beat read to slave 2 at 0x8000_0000.
    set_in(0, 2, 1, 4'hf, 4'h0, 4'h0, 0);
    S00_AXI_araddr = 32'h8000_0000;
    settle();
    chk("single_arvalid", int'(M_arvalid), 4'b0100);
    chk("single_arready", int'(S00_AXI_arready), 1);
    tick();
    for (int b = 0; b < 4; b++) begin
      set_in(0, 0, 0, 4'h0, 4'b0100, (b == 3) ? 4'b0100 : 4'h0, 1);
      settle();
      chk($sformatf("single_beat%0d_rsel", b), int'(r_sel), 2);
      chk($sformatf("single_beat%0d_outst", b), int'(outstanding), 1);
      tick();
    end
    set_in(0, 0, 0, 4'h0, 4'b0100, 4'h0, 1);
    settle();
    chk("single_after_outst", int'(outstanding), 0);
    chk("single_after_rvalid", int'(S00_AXI_rvalid), 0);
    tick();

    // Fill to MAX_OUTSTANDING with slave 3, then free one slot.
    for (int i = 0; i < MAXO; i++) begin
      set_in(0, 3, 1, 4'hf, 4'h0, 4'h0, 0);
      cyc();
    end
    set_in(0, 3, 1, 4'hf, 4'h0, 4'h0, 0);
    settle();
    chk("full_outst", int'(outstanding), 4);
    chk("full_arready", int'(S00_AXI_arready), 0);
    chk("full_arvalid", int'(M_arvalid), 0);
    tick();
    set_in(0, 3, 1, 4'hf, 4'b1000, 4'b1000, 1);
    settle();
    chk("full_pop_arready", int'(S00_AXI_arready), 0);
    tick();
    set_in(0, 3, 1, 4'hf, 4'h0, 4'h0, 0);
    settle();
    chk("full_after_outst", int'(outstanding), 3);
    chk("full_after_arready", int'(S00_AXI_arready), 1);
    tick();
    drain();

    // Slave 0 then slave 1: the second AR waits for slave 0 to drain.
    set_in(0, 0, 1, 4'hf, 4'h0, 4'h0, 0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 1, 4'hf, 4'h0, 4'h0, 0);
      settle();
      chk("order_hold_arvalid", int'(M_arvalid), 0);
      chk("order_hold_rsel", int'(r_sel), 0);
      tick();
    end
    set_in(0, 1, 1, 4'hf, 4'b0001, 4'b0001, 1);
    settle();
    chk("order_pop_arvalid", int'(M_arvalid), 0);
    chk("order_pop_rvalid", int'(S00_AXI_rvalid), 1);
    tick();
    set_in(0, 1, 1, 4'hf, 4'h0, 4'h0, 0);
    settle();
    chk("order_issue_arvalid", int'(M_arvalid), 4'b0010);
    tick();
    set_in(0, 1, 0, 4'h0, 4'h0, 4'h0, 0);
    settle();
    chk("order_new_rsel", int'(r_sel), 1);
    tick();
    drain();

    // Same-cycle push and pop at count 2, wrapping the pointers.
    set_in(0, 2, 1, 4'hf, 4'h0, 4'h0, 0);
    cyc();
    cyc();
    for (int i = 0; i < 10; i++) begin
      set_in(0, 2, 1, 4'hf, 4'b0100, 4'b0100, 1);
      settle();
      chk("simul_arready", int'(S00_AXI_arready), 1);
      chk("simul_rvalid", int'(S00_AXI_rvalid), 1);
      chk("simul_outst", int'(outstanding), 2);
      tick();
    end
    drain();

    // R backpressure, then a stray rvalid from a non-head slave.
    set_in(0, 1, 1, 4'hf, 4'h0, 4'h0, 0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 0, 4'h0, 4'b0011, 4'b0011, 0);
      settle();
      chk("bp_rvalid", int'(S00_AXI_rvalid), 1);
      chk("bp_rsel", int'(r_sel), 1);
      chk("bp_outst", int'(outstanding), 1);
      tick();
    end
    set_in(0, 0, 0, 4'h0, 4'b0001, 4'b0001, 1);
    settle();
    chk("stray_rvalid", int'(S00_AXI_rvalid), 0);
    tick();
    set_in(0, 0, 0, 4'h0, 4'h0, 4'h0, 0);
    settle();
    chk("stray_outst", int'(outstanding), 1);
    tick();
    drain();

    // Randomized traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 49) == 0, $urandom_range(0, 3),
             $urandom_range(0, 1) == 1, 4'($urandom), 4'($urandom),
             4'($urandom), $urandom_range(0, 3) != 0);
      cyc();
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
